uart_wrapper: RTL and testbench
===============================

# uart_wrapper

Copter-side link-layer block between the wireless UART pins and the command processor. Deserialises the 3-byte command frame (opcode, data high, data low) that the ground-side command master sends, then presents it as a parallel `cmd`/`data` word with a sticky ready flag. It also serialises the 1-byte response (`POS_ACK` = 8'hA5 or a battery reading) back over `TX`. UART receiver and transmitter are internal; 8N1, LSB first, idle high.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per bit (50 MHz / 19200 baud); must be ≥ 8.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `RX`  in  1  serial input from the radio; asynchronous to `clk`
- `TX`  out  1  serial output to the radio
- `cmd`  out  8  opcode of the last complete frame
- `data`  out  16  payload of the last complete frame, {byte2, byte3}
- `cmd_rdy`  out  1  sticky flag: a new frame is valid on `cmd`/`data`
- `clr_cmd_rdy`  in  1  one-cycle pulse from the consumer to knock down `cmd_rdy`
- `resp`  in  8  response byte to transmit
- `send_resp`  in  1  one-cycle pulse: start transmitting `resp`
- `resp_sent`  out  1  sticky flag: last response has fully left `TX`

## Operation
- Reset values: `TX`=1, `cmd`=8'h00, `data`=16'h0000, `cmd_rdy`=0, `resp_sent`=0. All FSMs go idle and any partial frame is discarded. Reset is effective mid-byte or mid-frame.
- RX path:
  - `RX` is double-flopped, with a third flop for falling-edge detection.
  - A start is a falling edge seen while the RX FSM is IDLE.
  - Bits are sampled at BAUD_DIV/2 (integer) after the edge, then every BAUD_DIV.
  - 10 samples are taken: start, D0..D7, stop.
  - If the start sample is high, the edge is treated as a glitch: return to IDLE with no byte.
  - After the stop sample, an internal `byte_rdy` pulses for 1 cycle.
  - RX FSM states: IDLE → RECV → IDLE.
- Frame FSM, advanced by `byte_rdy`:
  - WAIT_CMD: latch the byte into a shadow opcode register, go to WAIT_DH.
  - WAIT_DH: latch the shadow high byte, go to WAIT_DL.
  - WAIT_DL: load `cmd` ← shadow opcode and `data` ← {shadow high, byte}, set `cmd_rdy`, go to WAIT_CMD.
  - `cmd`/`data` change only on frame completion, so they stay stable while `cmd_rdy`=1.
  - No inter-byte timeout. A partial frame waits indefinitely.
- `cmd_rdy`:
  - Cleared by `clr_cmd_rdy`.
  - Also cleared when the first byte of the next frame is accepted (WAIT_CMD `byte_rdy`).
  - Set on frame completion takes priority over `clr_cmd_rdy` in the same cycle.
- TX path:
  - `send_resp` in TX IDLE latches `resp` into a 10-bit shift register {1, resp, 0}, clears `resp_sent`, and enters XMIT.
  - Each bit is held BAUD_DIV cycles.
  - After the stop bit's BAUD_DIV cycles, return to IDLE and set `resp_sent`.
  - `send_resp` while in XMIT is ignored: `resp` is not latched and `resp_sent` is unchanged.
  - RX and TX are fully independent and may run simultaneously.

## Timing
- `TX` drops to 0 on the first rising edge after the `send_resp` cycle.
- The frame occupies exactly 10×BAUD_DIV cycles.
- `resp_sent` rises in the cycle after the final stop-bit cycle.
- RX start-to-`byte_rdy` latency: 2 synchroniser cycles + 1 edge cycle + BAUD_DIV/2 + 9×BAUD_DIV, ±1 cycle.
- `cmd_rdy`, `cmd` and `data` update in the cycle after the third `byte_rdy`.
- Back-to-back bytes with a 1-bit-time stop bit and no idle gap must be received.
- RX needs the falling edge to be detectable within one bit time of the stop sample.
- Baud counter width is $clog2(BAUD_DIV). Counters restart at each start and at each bit boundary, with no cumulative drift.

## Configuration
- `UART_WRAPPER_FRM_CHK_EN`
- Defined: a low stop-bit sample suppresses `byte_rdy` for that byte and resets the frame FSM to WAIT_CMD, discarding the partial frame. `cmd`/`data`/`cmd_rdy` are untouched.
- Undefined: the stop-bit value is ignored and every byte is accepted.

## Test plan
- Reset with `RX`=1 → `TX`=1, `cmd_rdy`=0, `cmd`=00, `data`=0000, `resp_sent`=0. Assert `rst_n` low mid-byte → same values within 1 cycle, and the next full frame is received correctly.
- BAUD_DIV=16, send 02,00,01 back-to-back → `cmd_rdy`=1, `cmd`=8'h02, `data`=16'h0001. Pulse `clr_cmd_rdy` → `cmd_rdy`=0, while `cmd`/`data` hold.
- Send 03 then 00; check `cmd`/`data` unchanged mid-frame. Then send 02 → `cmd`=03, `data`=0002. Then send 05,00,03 without clearing → `cmd_rdy` drops on byte 05 and re-rises with `cmd`=05, `data`=0003.
- Assert `clr_cmd_rdy` in the exact cycle the third byte completes → `cmd_rdy`=1.
- `send_resp` with `resp`=A5 → `TX` waveform 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. `resp_sent` rises at cycle 161. A second `send_resp` with `resp`=3C during transmission is ignored, and A5 is still output.
- Frame check (macro on): a byte with a low stop bit mid-frame → no `cmd_rdy`, and the next 01,12,34 gives `cmd`=01, `data`=1234. Macro off: the same stimulus completes a frame using the bad byte.

Source files
------------

// File: rtl/uart_wrapper.sv
`default_nettype none
// ============================================================================
//  Module   : uart_wrapper
//  Purpose  : Copter-side link layer. An internal 8N1 receiver (LSB first,
//             idle high) collects 3-byte command frames {opcode, data_hi,
//             data_lo} and presents them as cmd/data with a sticky cmd_rdy.
//             An internal transmitter sends a 1-byte response on TX.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             RX, TX           - serial in (async to clk) / serial out
//             cmd, data        - opcode and {byte2, byte3} of last frame
//             cmd_rdy          - sticky "new frame valid" flag
//             clr_cmd_rdy      - pulse to knock cmd_rdy down
//             resp, send_resp  - response byte and start-transmit pulse
//             resp_sent        - sticky "response has fully left TX" flag
//  Params   : BAUD_DIV         - clock cycles per bit (>= 8)
//  Macros   : UART_WRAPPER_FRM_CHK_EN - when defined, a byte whose stop
//             sample is low is dropped and the partial frame is discarded.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // --------------------------------------------------------------------------
  // RX synchroniser plus one extra stage for falling-edge detection
  // --------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // --------------------------------------------------------------------------
  // RX byte FSM
  // --------------------------------------------------------------------------
  typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;      // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    rx_shift;
  logic          byte_rdy;
  logic          frame_err;
  logic          rx_sample;

  // Start bit is sampled half a bit after the edge, later bits a full bit on;
  // the counter restarts at every sample so timing error never accumulates.
  assign rx_sample = (rx_bit == 4'd0) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 4'd0;
      rx_shift  <= 8'h00;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_RECV;
            rx_cnt   <= '0;
            rx_bit   <= 4'd0;
          end
        end
        RX_RECV: begin
          if (rx_sample) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
              // Start sample high: the edge was a glitch
              if (rx_s2) rx_state <= RX_IDLE;
            end else if (rx_bit == 4'd9) begin
              rx_state <= RX_IDLE;
`ifdef UART_WRAPPER_FRM_CHK_EN
              if (rx_s2) byte_rdy  <= 1'b1;
              else       frame_err <= 1'b1;
`else
              byte_rdy <= 1'b1;
`endif
            end else begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame assembly FSM. cmd/data only move on frame completion, so they are
  // stable for the whole time cmd_rdy is high.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_DH  = 2'd1,
    WAIT_DL  = 2'd2
  } frm_state_t;

  frm_state_t frm_state;
  logic [7:0] op_shadow;
  logic [7:0] hi_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_state <= WAIT_CMD;
      op_shadow <= 8'h00;
      hi_shadow <= 8'h00;
      cmd       <= 8'h00;
      data      <= 16'h0000;
      cmd_rdy   <= 1'b0;
    end else begin
      if (frame_err) begin
        frm_state <= WAIT_CMD;
      end else if (byte_rdy) begin
        case (frm_state)
          WAIT_CMD: begin
            op_shadow <= rx_shift;
            frm_state <= WAIT_DH;
          end
          WAIT_DH: begin
            hi_shadow <= rx_shift;
            frm_state <= WAIT_DL;
          end
          WAIT_DL: begin
            cmd       <= op_shadow;
            data      <= {hi_shadow, rx_shift};
            frm_state <= WAIT_CMD;
          end
          default: frm_state <= WAIT_CMD;
        endcase
      end

      // Completion wins over a simultaneous clear
      if (byte_rdy && (frm_state == WAIT_DL))
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (byte_rdy && (frm_state == WAIT_CMD)))
        cmd_rdy <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM. TX is driven straight from a register; the shift register keeps
  // the next bit in position [1] so it can be loaded into TX at a boundary.
  // --------------------------------------------------------------------------
  typedef enum logic {TX_IDLE = 1'b0, TX_XMIT = 1'b1} tx_state_t;

  tx_state_t     tx_state;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= 10'h3FF;
      tx_cnt    <= '0;
      tx_bit    <= 4'd0;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift  <= {1'b1, resp, 1'b0};
            TX        <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= 4'd0;
            resp_sent <= 1'b0;
            tx_state  <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              TX        <= 1'b1;
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              TX       <= tx_shift[1];
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bit   <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_wrapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_wrapper
//  Purpose  : Directed self-checking bench for uart_wrapper at BAUD_DIV=16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_wrapper;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int checks   = 0;
  int failures = 0;

  uart_wrapper #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one 8N1 byte. With clr_at_stop the consumer
  // clear is placed on the cycle the third byte of a frame completes.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic clr_at_stop);
    logic [9:0] frm;
    frm = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      RX = frm[j];
      if (j == 9 && clr_at_stop) begin
        repeat (11) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (BD) @(negedge clk);
      end
    end
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1, 1'b0);
    send_byte(b1, 1'b1, 1'b0);
    send_byte(b2, 1'b1, 1'b0);
  endtask

  // Transmits A5, tries to start 3C mid-byte, checks each bit at mid-bit.
  task automatic tx_check();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    resp = 8'hA5;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int cyc = 1; cyc <= 160; cyc++) begin
      @(negedge clk);
      if (cyc % BD == BD / 2) check_val($sformatf("tx_bit%0d", cyc / BD), TX, exp_bits[cyc / BD]);
      if (cyc == 50) begin
        resp = 8'h3C;
        send_resp = 1'b1;
      end
      if (cyc == 51) send_resp = 1'b0;
      if (cyc == 159) check_val("resp_sent_before_end", resp_sent, 1'b0);
      if (cyc == 160) begin
        check_val("resp_sent_at_end", resp_sent, 1'b1);
        check_val("tx_idle_after", TX, 1'b1);
      end
    end
    idle(40);
    check_val("tx_no_retransmit", TX, 1'b1);
    check_val("resp_sent_held", resp_sent, 1'b1);
  endtask

  initial begin
    // Reset
    idle(3);
    check_val("rst_tx", TX, 1'b1);
    check_val("rst_cmd_rdy", cmd_rdy, 1'b0);
    check_val("rst_cmd", cmd, 8'h00);
    check_val("rst_data", data, 16'h0000);
    check_val("rst_resp_sent", resp_sent, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Back-to-back frame and consumer clear
    send_frame(8'h02, 8'h00, 8'h01);
    idle(2);
    check_val("f1_rdy", cmd_rdy, 1'b1);
    check_val("f1_cmd", cmd, 8'h02);
    check_val("f1_data", data, 16'h0001);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    idle(1);
    check_val("clr_rdy", cmd_rdy, 1'b0);
    check_val("clr_cmd_hold", cmd, 8'h02);
    check_val("clr_data_hold", data, 16'h0001);

    // Partial frame keeps outputs stable
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    idle(2);
    check_val("mid_cmd", cmd, 8'h02);
    check_val("mid_data", data, 16'h0001);
    check_val("mid_rdy", cmd_rdy, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    idle(2);
    check_val("f2_rdy", cmd_rdy, 1'b1);
    check_val("f2_cmd", cmd, 8'h03);
    check_val("f2_data", data, 16'h0002);

    // Next frame's first byte drops cmd_rdy without a clear
    send_byte(8'h05, 1'b1, 1'b0);
    idle(2);
    check_val("f3_first_byte_rdy", cmd_rdy, 1'b0);
    check_val("f3_first_byte_cmd", cmd, 8'h03);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    idle(2);
    check_val("f3_rdy", cmd_rdy, 1'b1);
    check_val("f3_cmd", cmd, 8'h05);
    check_val("f3_data", data, 16'h0003);

    // Clear coincident with frame completion: set wins
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b1);
    idle(2);
    check_val("coinc_rdy", cmd_rdy, 1'b1);
    check_val("coinc_cmd", cmd, 8'h11);
    check_val("coinc_data", data, 16'h2233);

    // Short low glitch must not produce a byte
    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(40);
    send_frame(8'h44, 8'h55, 8'h66);
    idle(2);
    check_val("glitch_cmd", cmd, 8'h44);
    check_val("glitch_data", data, 16'h5566);

    // TX response running concurrently with an RX frame
    fork
      tx_check();
      send_frame(8'h21, 8'h43, 8'h65);
    join
    idle(2);
    check_val("conc_cmd", cmd, 8'h21);
    check_val("conc_data", data, 16'h4365);

    // Reset in the middle of the second byte of a frame
    send_byte(8'h77, 1'b1, 1'b0);
    RX = 1'b0;
    idle(40);
    rst_n = 1'b0;
    #1;
    check_val("mrst_tx", TX, 1'b1);
    check_val("mrst_cmd_rdy", cmd_rdy, 1'b0);
    check_val("mrst_cmd", cmd, 8'h00);
    check_val("mrst_data", data, 16'h0000);
    check_val("mrst_resp_sent", resp_sent, 1'b0);
    @(negedge clk);
    RX = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    send_frame(8'h0A, 8'hBC, 8'hDE);
    idle(2);
    check_val("post_rst_rdy", cmd_rdy, 1'b1);
    check_val("post_rst_cmd", cmd, 8'h0A);
    check_val("post_rst_data", data, 16'hBCDE);

    // Low stop bit in the middle of a frame
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_byte(8'h07, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    idle(32);
    check_val("badstop_rdy", cmd_rdy, 1'b0);
    send_frame(8'h01, 8'h12, 8'h34);
    idle(2);
`ifdef UART_WRAPPER_FRM_CHK_EN
    check_val("frmchk_rdy", cmd_rdy, 1'b1);
    check_val("frmchk_cmd", cmd, 8'h01);
    check_val("frmchk_data", data, 16'h1234);
`else
    check_val("nofrmchk_rdy", cmd_rdy, 1'b0);
    check_val("nofrmchk_cmd", cmd, 8'h07);
    check_val("nofrmchk_data", data, 16'h5501);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
